regblock_pipe: RTL
==================

Name: regblock_pipe

Overview:
- Parametrised successor to the operand-fetch register block.
- Contains a 2^RWIDTH x DWIDTH register file with 2 read ports and 1 write port.
- Adds a selectable immediate extension mode, write-to-read bypass, an optional hardwired zero register, and one pipeline register on the operand outputs with a valid/stall handshake.
- Sits between decode and the ALU. opA, opB and opBwd feed the execute stage.

Parameters:
- RWIDTH, 6: register address width; depth is 2^RWIDTH.
- DWIDTH, 32: data width.
- IMM_IN, 15: immediate field width; must be less than DWIDTH.
- ZERO_REG, 1: 1 means register 0 reads as 0 and writes to it are ignored; 0 means register 0 behaves like any other register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decode presents a valid rs/rt/imm_in/mux_sel/imm_sign.
- stall  in  1  execute cannot accept; the output register holds its contents.
- rs  in  RWIDTH  read address A.
- rt  in  RWIDTH  read address B.
- rd  in  RWIDTH  write address.
- wd  in  DWIDTH  write data.
- we  in  1  write enable.
- mux_sel  in  1  0 selects register rt for opB; 1 selects the extended immediate for opB.
- imm_sign  in  1  1 sign-extends imm_in; 0 zero-extends imm_in.
- imm_in  in  IMM_IN  immediate field.
- out_valid  out  1  the output register holds a valid operand set.
- opA  out  DWIDTH  registered value of register rs.
- opB  out  DWIDTH  registered value of either register rt or the extended immediate.
- opBwd  out  DWIDTH  registered value of register rt, regardless of mux_sel (store data).

Behaviour:
- Reset (rst=1 at a clock edge):
  - every register-file entry is cleared to 0;
  - opA, opB and opBwd go to 0, out_valid goes to 0;
  - the captured addresses go to 0;
  - writes presented in the same cycle are dropped.
- Reset wins over every other input. Asserting reset mid-stall discards the held operands.
- Write: when we=1 and rst=0, mem[rd] takes wd at the edge. If ZERO_REG=1 and rd=0, the write is ignored. Writes occur regardless of stall.
- Read, comb, feeding the output register:
  - rA = 0 if (ZERO_REG and rs=0);
  - otherwise rA = wd if (we and rd=rs);
  - otherwise rA = mem[rs].
  - rB is computed the same way using rt (same-cycle write-first bypass).
- Extension: ext = {(DWIDTH-IMM_IN) copies of (imm_sign ? imm_in[IMM_IN-1] : 0), imm_in}.
- Latency: one cycle from inputs to outputs.
- When stall=0, at the edge:
  - opA <= rA;
  - opBwd <= rB;
  - opB <= (mux_sel ? ext : rB);
  - out_valid <= in_valid;
  - captured rs/rt/mux_sel <= current values.
- Outputs load whenever stall=0, even if in_valid=0; only out_valid qualifies them.
- When stall=1, the outputs and out_valid hold, with one refresh rule:
  - if we=1 and rd equals the captured rs (not a zero-reg hit), opA <= wd;
  - if rd equals the captured rt, opBwd <= wd, and opB <= wd when the captured mux_sel=0.
  - This keeps held operands coherent with writeback.
- rs=rt is legal; both ports return the same value.
- rd equal to both rs and rt with we=1 bypasses to both ports.
- Addresses wrap naturally within RWIDTH; there is no out-of-range case.

Test Plan:
1. Reset then read: rst=1 for 1 cycle, then rs=5, rt=9, mux_sel=0, in_valid=1 -> next cycle opA=0, opB=0, out_valid=1.
2. Write then read: we=1, rd=3, wd=0xDEADBEEF; next cycle rs=3, rt=3, mux_sel=0 -> one cycle later opA=opB=opBwd=0xDEADBEEF.
3. Same-cycle bypass: we=1, rd=7, wd=0x12345678, with rs=7 in the same cycle -> next cycle opA=0x12345678. A write of 0x55 to rd=0 followed by rs=0 -> opA=0 (ZERO_REG=1).
4. Immediate modes: imm_in=15'h7FFF, mux_sel=1:
   - imm_sign=1 -> opB=0xFFFFFFFF;
   - imm_sign=0 -> opB=0x00007FFF;
   - in both cases opBwd equals register rt.
5. Stall hold and refresh:
   - capture rs=4, rt=6 (values 0xA, 0xB), then stall=1 -> outputs hold for 3 cycles;
   - we=1, rd=6, wd=0xC during the stall -> opBwd=opB=0xC, opA stays 0xA;
   - release the stall -> new operands load.
6. Reset mid-operation: out_valid=1 with stall=1 and we=1, then rst=1 -> next cycle out_valid=0, all outputs 0, and a later read of rd returns 0.

Source files
------------

// File: rtl/regblock_pipe.sv
// rtl/regblock_pipe.sv - register file with write-first bypass, immediate extension and a stallable operand register
module regblock_pipe #(
  parameter int RWIDTH   = 6,
  parameter int DWIDTH   = 32,
  parameter int IMM_IN   = 15,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              stall,
  input  logic [RWIDTH-1:0] rs,
  input  logic [RWIDTH-1:0] rt,
  input  logic [RWIDTH-1:0] rd,
  input  logic [DWIDTH-1:0] wd,
  input  logic              we,
  input  logic              mux_sel,
  input  logic              imm_sign,
  input  logic [IMM_IN-1:0] imm_in,
  output logic              out_valid,
  output logic [DWIDTH-1:0] opA,
  output logic [DWIDTH-1:0] opB,
  output logic [DWIDTH-1:0] opBwd
);

  localparam int  DEPTH   = 1 << RWIDTH;
  localparam bit  ZERO_EN = (ZERO_REG != 0);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [RWIDTH-1:0] cap_rs;
  logic [RWIDTH-1:0] cap_rt;
  logic              cap_sel;

  logic              wr_en;
  logic              rs_zero;
  logic              rt_zero;
  logic [DWIDTH-1:0] r_a;
  logic [DWIDTH-1:0] r_b;
  logic [DWIDTH-1:0] ext;

  // A write to the hardwired zero register is a no-op everywhere, including the bypass paths.
  assign wr_en   = we && !(ZERO_EN && (rd == '0));
  assign rs_zero = ZERO_EN && (rs == '0);
  assign rt_zero = ZERO_EN && (rt == '0);

  always_comb begin
    r_a = mem[rs];
    if (rs_zero) begin
      r_a = '0;
    end else if (wr_en && (rd == rs)) begin
      r_a = wd;
    end
  end

  always_comb begin
    r_b = mem[rt];
    if (rt_zero) begin
      r_b = '0;
    end else if (wr_en && (rd == rt)) begin
      r_b = wd;
    end
  end

  assign ext = {{(DWIDTH-IMM_IN){imm_sign & imm_in[IMM_IN-1]}}, imm_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      out_valid <= 1'b0;
      opA       <= '0;
      opB       <= '0;
      opBwd     <= '0;
      cap_rs    <= '0;
      cap_rt    <= '0;
      cap_sel   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[rd] <= wd;
      end
      if (!stall) begin
        opA       <= r_a;
        opBwd     <= r_b;
        opB       <= mux_sel ? ext : r_b;
        out_valid <= in_valid;
        cap_rs    <= rs;
        cap_rt    <= rt;
        cap_sel   <= mux_sel;
      end else begin
        // Held operands track writeback so execute never consumes a stale register value.
        if (wr_en && (rd == cap_rs)) begin
          opA <= wd;
        end
        if (wr_en && (rd == cap_rt)) begin
          opBwd <= wd;
          if (!cap_sel) begin
            opB <= wd;
          end
        end
      end
    end
  end

endmodule
